// File: rtl/motor_pkg.sv
// Shared constants for the motor input conditioning block and its controller bench.
package motor_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

  // Debounce counter width; a 1-bit floor keeps tiny debounce settings legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioning channel: multi-flop synchronizer followed by a
// consecutive-stable-cycle debouncer holding the clean level.
module debounce_chan
  import motor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any cycle of agreement drops the count back to zero; the last differing
  // cycle flips the clean level and clears the count together.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (synced != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/motor_input_cond.sv
// Conditions the push-button and both limit switches, producing a one-shot
// activate request that is suppressed while both limits report active.
module motor_input_cond
  import motor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic up_limit_raw,
  input  logic dn_limit_raw,
  output logic activate,
  output logic up_limit,
  output logic dn_limit,
  output logic limit_fault
);

  logic btn_clean, up_clean, dn_clean;
  logic act_q, act_d;
  logic btn_prev_q;
  logic fault_q, fault_d;

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk(clk), .rst_n(rst_n), .raw_i(btn_raw), .clean_o(btn_clean)
  );

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .raw_i(up_limit_raw), .clean_o(up_clean)
  );

  debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk(clk), .rst_n(rst_n), .raw_i(dn_limit_raw), .clean_o(dn_clean)
  );

  // A press landing while the fault is held or just rising is dropped outright;
  // btn_prev_q still tracks it, so no late pulse follows when the fault clears.
  always_comb begin
    fault_d = up_clean & dn_clean;
    act_d   = btn_clean & ~btn_prev_q & ~(fault_q | fault_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      act_q      <= act_d;
      btn_prev_q <= btn_clean;
      fault_q    <= fault_d;
    end
  end

  assign activate    = act_q;
  assign up_limit    = up_clean;
  assign dn_limit    = dn_clean;
  assign limit_fault = fault_q;

endmodule

// File: tb/tb_motor_input_cond.sv
// Bench for motor_input_cond with short debounce settings: table vectors,
// directed multi-cycle sequences and randomized runs against a window model.
module tb_motor_input_cond;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0, up_raw = 1'b0, dn_raw = 1'b0;
  logic activate, up_limit, dn_limit, limit_fault;

  always #5 clk = ~clk;

  motor_input_cond #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .up_limit_raw(up_raw),
    .dn_limit_raw(dn_raw), .activate(activate), .up_limit(up_limit),
    .dn_limit(dn_limit), .limit_fault(limit_fault)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ecnt = 0;

  // Reference model: a clean level flips once the last DEB synchronized
  // samples all disagree with it; synchronized = raw sampled SYNC edges ago.
  logic [2:0]  m_clean;
  logic [15:0] m_rawh [3];
  logic [15:0] m_synh [3];
  logic        m_prev, m_act, m_fault;

  task automatic model_reset();
    m_clean = '0; m_prev = 1'b0; m_act = 1'b0; m_fault = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      m_rawh[ch] = '0;
      m_synh[ch] = '0;
    end
  endtask

  task automatic model_edge();
    logic [2:0]  raw, old;
    logic        s;
    logic [15:0] mask;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw  = {dn_raw, up_raw, btn_raw};
    old  = m_clean;
    mask = 16'((1 << DEB) - 1);
    m_act   = old[0] & ~m_prev & ~(m_fault | (old[1] & old[2]));
    m_fault = old[1] & old[2];
    m_prev  = old[0];
    for (int ch = 0; ch < 3; ch++) begin
      s = m_rawh[ch][SYNC-1];
      m_rawh[ch] = {m_rawh[ch][14:0], raw[ch]};
      m_synh[ch] = {m_synh[ch][14:0], s};
      if (!old[ch] && ((m_synh[ch] & mask) == mask)) m_clean[ch] = 1'b1;
      else if (old[ch] && ((m_synh[ch] & mask) == 16'd0)) m_clean[ch] = 1'b0;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, got, exp, ecnt, $time);
  endtask

  function automatic int outs();
    return int'({activate, up_limit, dn_limit, limit_fault});
  endfunction

  function automatic int mouts();
    return int'({m_act, m_clean[1], m_clean[2], m_fault});
  endfunction

  task automatic tick(input bit cmp);
    @(posedge clk);
    model_edge();
    ecnt++;
    #1;
    if (cmp) check("model", outs(), mouts());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_outs", outs(), 0);
    tick(0);
    tick(0);
    rst_n = 1'b1;
    ecnt = 0;
  endtask

  typedef struct {
    logic       btn, up, dn;
    int         hold;
    int         exp_pulses;
    logic [2:0] exp_lvl;   // {up_limit, dn_limit, limit_fault}
  } vec_t;

  vec_t vt [10];

  int first, pulses, seen;
  int run_left [3];
  logic [2:0] rval;

  initial begin
    model_reset();

    // ---------------- table vectors ----------------
    vt[0] = '{1'b0, 1'b0, 1'b0, 10, 0, 3'b000};
    vt[1] = '{1'b0, 1'b1, 1'b0, 10, 0, 3'b100};
    vt[2] = '{1'b0, 1'b1, 1'b1, 10, 0, 3'b111};
    vt[3] = '{1'b1, 1'b1, 1'b1, 10, 0, 3'b111};
    vt[4] = '{1'b1, 1'b0, 1'b0, 10, 0, 3'b000};
    vt[5] = '{1'b0, 1'b0, 1'b0, 10, 0, 3'b000};
    vt[6] = '{1'b1, 1'b0, 1'b0, 10, 1, 3'b000};
    vt[7] = '{1'b0, 1'b0, 1'b0, 10, 0, 3'b000};
    vt[8] = '{1'b1, 1'b1, 1'b0, 10, 1, 3'b100};
    vt[9] = '{1'b0, 1'b0, 1'b1, 10, 0, 3'b010};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_raw = vt[i].btn; up_raw = vt[i].up; dn_raw = vt[i].dn;
      pulses = 0;
      repeat (vt[i].hold) begin
        tick(1);
        if (activate) pulses++;
      end
      check($sformatf("vec%0d_pulses", i), pulses, vt[i].exp_pulses);
      check($sformatf("vec%0d_levels", i), int'({up_limit, dn_limit, limit_fault}), int'(vt[i].exp_lvl));
    end

    // ---------------- single press, long hold ----------------
    btn_raw = 0; up_raw = 0; dn_raw = 0;
    do_reset();
    while (ecnt < 10) tick(1);
    btn_raw = 1'b1;
    first = -1; pulses = 0;
    repeat (100) begin
      tick(1);
      if (activate) begin
        pulses++;
        if (first < 0) first = ecnt;
      end
    end
    check("press_pulse_edge", first, 17);
    check("press_pulse_count", pulses, 1);

    // ---------------- bouncing button ----------------
    btn_raw = 0;
    do_reset();
    pulses = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = ((i / 2) % 2) == 0;
      tick(1);
      if (activate) pulses++;
      if (dut.btn_clean) seen++;
    end
    btn_raw = 1'b0;
    repeat (20) begin
      tick(1);
      if (activate) pulses++;
      if (dut.btn_clean) seen++;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_clean_high", seen, 0);

    // ---------------- limit glitch filtering ----------------
    btn_raw = 0;
    do_reset();
    up_raw = 1'b1;
    while (ecnt < 40) tick(1);
    check("up_settled", int'(up_limit), 1);
    up_raw = 1'b0;
    repeat (3) tick(1);
    up_raw = 1'b1;
    seen = 0;
    while (ecnt < 60) begin
      tick(1);
      if (!up_limit) seen++;
    end
    check("glitch3_up_low", seen, 0);
    while (ecnt < 70) tick(1);
    up_raw = 1'b0;
    first = -1;
    repeat (4) begin
      tick(1);
      if (!up_limit && first < 0) first = ecnt;
    end
    up_raw = 1'b1;
    while (ecnt < 90) begin
      tick(1);
      if (!up_limit && first < 0) first = ecnt;
    end
    check("glitch4_up_low_edge", first, 76);

    // ---------------- fault blocks activate ----------------
    up_raw = 0;
    do_reset();
    while (ecnt < 5) tick(1);
    up_raw = 1'b1;
    while (ecnt < 8) tick(1);
    dn_raw = 1'b1;
    first = -1;
    while (ecnt < 20) begin
      tick(1);
      if (limit_fault && first < 0) first = ecnt;
    end
    check("fault_rise_edge", first, 15);
    btn_raw = 1'b1;
    pulses = 0;
    while (ecnt < 30) begin
      tick(1);
      if (activate) pulses++;
    end
    btn_raw = 1'b0; up_raw = 1'b0; dn_raw = 1'b0;
    while (ecnt < 45) begin
      tick(1);
      if (activate) pulses++;
    end
    check("fault_press_pulses", pulses, 0);
    check("fault_cleared", int'(limit_fault), 0);
    btn_raw = 1'b1;
    pulses = 0;
    while (ecnt < 60) begin
      tick(1);
      if (activate) pulses++;
    end
    check("post_fault_pulses", pulses, 1);

    // ---------------- reset mid-count ----------------
    btn_raw = 0;
    do_reset();
    up_raw = 1'b1;
    while (ecnt < 10) tick(1);
    btn_raw = 1'b1;
    while (ecnt < 14) tick(1);
    check("btn_cnt_before_reset", int'(dut.u_btn.cnt_q), 2);
    check("up_before_reset", int'(up_limit), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_outs", outs(), 0);
    tick(1);
    tick(1);
    rst_n = 1'b1;
    ecnt = 0;
    first = -1; pulses = 0;
    while (ecnt < 20) begin
      tick(1);
      if (activate) begin
        pulses++;
        if (first < 0) first = ecnt;
      end
    end
    check("post_reset_pulse_edge", first, 7);
    check("post_reset_pulse_count", pulses, 1);

    // ---------------- randomized run against model ----------------
    btn_raw = 0; up_raw = 0; dn_raw = 0;
    do_reset();
    for (int ch = 0; ch < 3; ch++) run_left[ch] = 0;
    rval = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (run_left[ch] == 0) begin
          rval[ch] = 1'($urandom_range(0, 1));
          run_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                                     : int'($urandom_range(1, 6));
        end
        run_left[ch]--;
      end
      btn_raw = rval[0]; up_raw = rval[1]; dn_raw = rval[2];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rand_async_reset", outs(), 0);
        tick(1);
        tick(1);
        rst_n = 1'b1;
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/motor_input_cond.md
MOTOR_INPUT_COND -- requirements
Module: motor_input_cond

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth per raw input (minimum 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, sets the consecutive stable cycles required before a clean output changes (minimum 2).
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port btn_raw  input  1  asynchronous push-button, active-high, bouncy.
REQ-006 Port up_limit_raw  input  1  asynchronous upper limit switch, active-high, bouncy.
REQ-007 Port dn_limit_raw  input  1  asynchronous lower limit switch, active-high, bouncy.
REQ-008 Port activate  output  1  single-cycle request pulse to the motor controller.
REQ-009 Port up_limit  output  1  debounced upper limit level.
REQ-010 Port dn_limit  output  1  debounced lower limit level.
REQ-011 Port limit_fault  output  1  high while both debounced limits are asserted.

Function
REQ-012 Each raw input SHALL pass through a SYNC_STAGES flop synchronizer before any other use.
REQ-013 Each channel SHALL hold a clean level and a counter; the counter clears whenever the synced value equals the clean level.
REQ-014 The counter SHALL increment on every cycle where the synced value differs from the clean level.
REQ-015 When the synced value differs and the counter equals DEBOUNCE_CYCLES-1, the clean level SHALL take the synced value and the counter SHALL clear on the same edge.
REQ-016 A single cycle of agreement during counting SHALL restart the count from zero (no partial credit).
REQ-017 Raw-to-clean latency SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges for a clean step input.
REQ-018 up_limit and dn_limit SHALL be the registered clean levels of their channels.
REQ-019 activate SHALL be a registered pulse, high for exactly one cycle, on the edge after the clean button level rises 0->1.
REQ-020 activate SHALL NOT repeat while the button stays pressed; a new pulse requires a clean release followed by a clean press.
REQ-021 limit_fault SHALL equal clean up AND clean dn, registered, with one cycle of latency after the later limit settles.
REQ-022 A clean button rising edge coinciding with limit_fault high, or with limit_fault rising on the same edge, SHALL be discarded, with no deferred pulse.
REQ-023 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear all synchronizer flops, counters, clean levels, activate, up_limit, dn_limit and limit_fault to 0.
REQ-025 Reset asserted mid-count SHALL discard progress; after release each channel restarts from a clean level of 0 and a count of 0.
REQ-026 A raw input already high at reset release SHALL produce its clean high after the full REQ-017 latency; for the button this also yields one activate pulse.

Structure
REQ-027 The package motor_pkg SHALL hold the default DEBOUNCE_CYCLES and SYNC_STAGES constants shared with the motor controller bench.
REQ-028 The sub-module debounce_chan (synchronizer, counter and clean level) SHALL be instantiated three times; edge detect and fault logic SHALL reside in the top level.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 btn_raw 0->1 at edge 10, held for 100 cycles -> activate high only at edge 17, with no further pulse.
REQ-030 btn_raw toggling every 2 cycles for 20 cycles, then 0 -> activate never asserted, and the clean button stays 0.
REQ-031 up_limit_raw held 1, with a 3-cycle low glitch at edge 40 -> up_limit stays 1 throughout; a 4-cycle low produces up_limit 0 six edges after the glitch starts.
REQ-032 up_limit_raw=1 and dn_limit_raw=1 -> limit_fault rises 7 edges after the later raw edge; a btn press during the fault -> no activate; after the fault clears, a fresh press -> one pulse.
REQ-033 rst_n pulsed low while the btn counter equals 2 -> all outputs 0 asynchronously; btn held high -> activate 7 edges after rst_n release.
